axis_rx_frame_fifo: RTL and testbench

AXIS_RX_FRAME_FIFO -- requirements
Module: axis_rx_frame_fifo

---
 rtl/axis_rx_frame_fifo.sv | 149 ++++++++++++++
 tb/tb_axis_rx_frame_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_frame_fifo.sv
// Store-and-forward Rx frame FIFO: frames become visible downstream only once their tlast beat arrives with tuser clear.
// Define AXIS_RX_FIFO_STATS_EN to build the saturating good/error/overflow frame counters.
module axis_rx_frame_fifo #(
    parameter int ADDR_W = 9
) (
    input  logic        i_rxc,
    input  logic        i_reset_n,
    input  logic [63:0] s00_axis_tdata,
    input  logic [7:0]  s00_axis_tkeep,
    input  logic        s00_axis_tvalid,
    input  logic        s00_axis_tlast,
    input  logic        s00_axis_tuser,
    output logic [63:0] m00_axis_tdata,
    output logic [7:0]  m00_axis_tkeep,
    output logic        m00_axis_tvalid,
    output logic        m00_axis_tlast,
    input  logic        m00_axis_tready,
    output logic [15:0] o_good_frames,
    output logic [15:0] o_err_drops,
    output logic [15:0] o_ovf_drops
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [72:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_tmp;
    logic [ADDR_W:0] wr_cmt;
    logic [ADDR_W:0] wr_cmt_rd;
    logic [ADDR_W:0] rd_ptr;
    logic [1:0]      state;

    logic in_drop;
    logic full;
    logic wr_en;
    logic ovf_hit;
    logic commit;
    logic rollback;
    logic ram_avail;
    logic load;

    always_comb begin
        in_drop  = (state == ST_DROP);
        full     = ((wr_tmp - rd_ptr) == PTR_FULL);
        wr_en    = s00_axis_tvalid && !in_drop && !full;
        ovf_hit  = s00_axis_tvalid && !in_drop && full;
        commit   = wr_en && s00_axis_tlast && !s00_axis_tuser;
        rollback = (wr_en && s00_axis_tlast && s00_axis_tuser) || ovf_hit;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_rxc) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            wr_tmp <= '0;
            wr_cmt <= '0;
        end else begin
            if (commit) begin
                wr_tmp <= wr_tmp + PTR_ONE;
                wr_cmt <= wr_tmp + PTR_ONE;
            end else if (rollback) begin
                wr_tmp <= wr_cmt;
            end else if (wr_en) begin
                wr_tmp <= wr_tmp + PTR_ONE;
            end

            // Once a frame overflows, its remaining beats are swallowed until tlast.
            if (s00_axis_tvalid) begin
                if (s00_axis_tlast)
                    state <= ST_IDLE;
                else if (in_drop || full)
                    state <= ST_DROP;
                else
                    state <= ST_FRAME;
            end
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which words are valid.
    always_ff @(posedge i_rxc) begin
        if (wr_en)
            mem[wr_tmp[ADDR_W-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
    end

    // Read side tracks a one-cycle-delayed copy of the commit pointer, giving a fixed
    // two-cycle tlast-to-output latency and never reading a word on the edge it is written.
    assign ram_avail = (wr_cmt_rd != rd_ptr);
    assign load      = ram_avail && (!m00_axis_tvalid || m00_axis_tready);

    always_ff @(posedge i_rxc) begin
        if (!i_reset_n) begin
            wr_cmt_rd       <= '0;
            rd_ptr          <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tkeep  <= '0;
            m00_axis_tlast  <= 1'b0;
        end else begin
            wr_cmt_rd <= wr_cmt;
            if (load) begin
                {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} <= mem[rd_ptr[ADDR_W-1:0]];
                m00_axis_tvalid <= 1'b1;
                rd_ptr          <= rd_ptr + PTR_ONE;
            end else if (m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef AXIS_RX_FIFO_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;
    logic [15:0] ovf_cnt;
    logic        err_end;
    logic        ovf_end;

    assign err_end = wr_en && s00_axis_tlast && s00_axis_tuser;
    assign ovf_end = s00_axis_tvalid && s00_axis_tlast && (in_drop || full);

    always_ff @(posedge i_rxc) begin
        if (!i_reset_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (commit && good_cnt != 16'hFFFF)
                good_cnt <= good_cnt + 16'd1;
            if (err_end && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            if (ovf_end && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign o_good_frames = good_cnt;
    assign o_err_drops   = err_cnt;
    assign o_ovf_drops   = ovf_cnt;
`else
    assign o_good_frames = 16'h0000;
    assign o_err_drops   = 16'h0000;
    assign o_ovf_drops   = 16'h0000;
`endif

endmodule

// File: tb/tb_axis_rx_frame_fifo.sv
// Scoreboard bench for axis_rx_frame_fifo: frame-level reference model feeds an expected-word queue,
// an independent monitor compares every output transfer and checks stall stability.
module tb_axis_rx_frame_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef AXIS_RX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        i_rxc = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [63:0] s00_axis_tdata = '0;
    logic [7:0]  s00_axis_tkeep = '0;
    logic        s00_axis_tvalid = 1'b0;
    logic        s00_axis_tlast = 1'b0;
    logic        s00_axis_tuser = 1'b0;
    logic [63:0] m00_axis_tdata;
    logic [7:0]  m00_axis_tkeep;
    logic        m00_axis_tvalid;
    logic        m00_axis_tlast;
    logic        m00_axis_tready = 1'b0;
    logic [15:0] o_good_frames;
    logic [15:0] o_err_drops;
    logic [15:0] o_ovf_drops;

    axis_rx_frame_fifo #(.ADDR_W(ADDR_W)) dut (
        .i_rxc           (i_rxc),
        .i_reset_n       (i_reset_n),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tkeep  (s00_axis_tkeep),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tuser  (s00_axis_tuser),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tkeep  (m00_axis_tkeep),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready),
        .o_good_frames   (o_good_frames),
        .o_err_drops     (o_err_drops),
        .o_ovf_drops     (o_ovf_drops)
    );

    always #5 i_rxc = ~i_rxc;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } word_t;

    typedef enum int {F_GOOD, F_ERR, F_OVF} fate_t;

    word_t exp_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    pushed = 0;
    int    popped = 0;
    int    exp_good = 0;
    int    exp_err = 0;
    int    exp_ovf = 0;
    int    cyc = 0;
    int    ready_mode = 0;     // 0 = low, 1 = high, 2 = random
    bit    stalled = 1'b0;
    word_t held;
    bit    lat_armed = 1'b0;
    int    lat_cyc = 0;

    always @(posedge i_rxc) cyc <= cyc + 1;

    always @(posedge i_rxc) begin
        #1;
        case (ready_mode)
            0:       m00_axis_tready = 1'b0;
            1:       m00_axis_tready = 1'b1;
            default: m00_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
        if (!STATS)
            return 16'h0000;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // Monitor: compares each transfer against the scoreboard and checks hold during stalls.
    always @(negedge i_rxc) begin
        word_t cur;
        word_t e;
        cur = {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata};
        if (lat_armed && m00_axis_tvalid === 1'b1) begin
            lat_cyc   = cyc;
            lat_armed = 1'b0;
        end
        if (stalled)
            check("stall_hold", {m00_axis_tvalid, cur}, {1'b1, held});
        if (m00_axis_tvalid === 1'b1 && m00_axis_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_note("unexpected_out", $sformatf("data %h keep %h last %b with empty scoreboard",
                          m00_axis_tdata, m00_axis_tkeep, m00_axis_tlast));
            end else begin
                e = exp_q.pop_front();
                check("out_word", cur, e);
                popped++;
            end
        end
        stalled = (m00_axis_tvalid === 1'b1) && (m00_axis_tready === 1'b0);
        held    = cur;
    end

    task automatic tick();
        @(posedge i_rxc);
        #1;
    endtask

    task automatic idle(input int n);
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        s00_axis_tuser  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        ready_mode = 0;
        idle(2);
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        exp_q.delete();
        pushed   = 0;
        popped   = 0;
        exp_good = 0;
        exp_err  = 0;
        exp_ovf  = 0;
        stalled  = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_good"}, 80'(o_good_frames), 80'(exp_cnt(exp_good)));
        check({tag, "_err"},  80'(o_err_drops),   80'(exp_cnt(exp_err)));
        check({tag, "_ovf"},  80'(o_ovf_drops),   80'(exp_cnt(exp_ovf)));
    endtask

    // Reference model works per frame: good frames enter the scoreboard whole, others only bump a count.
    task automatic send_frame(input int len, input fate_t fate, input logic [7:0] last_keep,
                              input bit gaps, output int tlast_cyc);
        word_t w[$];
        word_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = (i == len - 1) ? last_keep : 8'hFF;
            b.last = (i == len - 1);
            w.push_back(b);
        end
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 7) == 0)
                idle(1);
            s00_axis_tvalid = 1'b1;
            s00_axis_tdata  = w[i].data;
            s00_axis_tkeep  = w[i].keep;
            s00_axis_tlast  = w[i].last;
            s00_axis_tuser  = w[i].last && (fate == F_ERR);
            if (w[i].last) begin
                case (fate)
                    F_GOOD: begin
                        foreach (w[k]) exp_q.push_back(w[k]);
                        pushed += len;
                        exp_good++;
                    end
                    F_ERR:   exp_err++;
                    default: exp_ovf++;
                endcase
            end
            tick();
        end
        tlast_cyc = cyc;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        s00_axis_tuser  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m00_axis_tvalid !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget)
            fail_note(name, $sformatf("%0d words still pending after %0d cycles", exp_q.size(), budget));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int tl;
        int len;
        int n;
        fate_t f;

        // Reset state
        do_reset();
        check("reset_out", {m00_axis_tvalid, m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata}, '0);
        check_counters("reset_cnt");

        // 8-beat good frame, partial last keep, latency of first word
        do_reset();
        ready_mode = 1;
        idle(3);
        lat_armed = 1'b1;
        send_frame(8, F_GOOD, 8'h0F, 1'b0, tl);
        wait_drain("drain_8beat", 100);
        check("latency_8beat", 80'(lat_cyc - tl), 80'(2));
        check("count_8beat", 80'(popped), 80'(8));
        check_counters("cnt_8beat");

        // Errored frame followed by a good frame
        do_reset();
        ready_mode = 1;
        send_frame(4, F_ERR, 8'hFF, 1'b0, tl);
        send_frame(3, F_GOOD, 8'h3F, 1'b0, tl);
        wait_drain("drain_err", 100);
        check("count_err", 80'(popped), 80'(3));
        check_counters("cnt_err");

        // Overflow with stalled output, then a frame that exactly fills the FIFO
        do_reset();
        ready_mode = 0;
        send_frame(20, F_OVF, 8'hFF, 1'b0, tl);
        idle(4);
        check("ovf_no_out", 80'(m00_axis_tvalid), 80'(0));
        check_counters("cnt_ovf");
        ready_mode = 1;
        send_frame(DEPTH, F_GOOD, 8'hFF, 1'b0, tl);
        wait_drain("drain_full", 200);
        check("count_full", 80'(popped), 80'(DEPTH));
        check_counters("cnt_full");

        // Single-beat frame
        do_reset();
        ready_mode = 1;
        send_frame(1, F_GOOD, 8'h01, 1'b0, tl);
        wait_drain("drain_single", 100);
        check("count_single", 80'(popped), 80'(1));
        check_counters("cnt_single");

        // Random back-to-back frames with random backpressure; admission keeps the FIFO from overflowing
        do_reset();
        ready_mode = 2;
        for (int fr = 0; fr < 100; fr++) begin
            len = $urandom_range(1, 8);
            f   = ($urandom_range(0, 4) == 0) ? F_ERR : F_GOOD;
            n   = 0;
            while ((pushed - popped + len > DEPTH) && n < 2000) begin
                idle(1);
                n++;
            end
            if (n >= 2000)
                fail_note("rand_admit", "output never drained enough to accept the next frame");
            send_frame(len, f, 8'(1 << $urandom_range(0, 7)) | 8'h01, 1'b1, tl);
        end
        wait_drain("drain_rand", 4000);
        check("count_rand", 80'(popped), 80'(pushed));
        check_counters("cnt_rand");

        // Reset mid-frame with two committed frames unread
        do_reset();
        ready_mode = 0;
        send_frame(3, F_GOOD, 8'hFF, 1'b0, tl);
        send_frame(2, F_GOOD, 8'hFF, 1'b0, tl);
        for (int i = 0; i < 3; i++) begin
            s00_axis_tvalid = 1'b1;
            s00_axis_tdata  = {$urandom, $urandom};
            s00_axis_tkeep  = 8'hFF;
            s00_axis_tlast  = 1'b0;
            tick();
        end
        s00_axis_tvalid = 1'b0;
        idle(3);
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        exp_q.delete();
        pushed   = 0;
        popped   = 0;
        exp_good = 0;
        exp_err  = 0;
        exp_ovf  = 0;
        stalled  = 1'b0;
        check("midreset_valid", 80'(m00_axis_tvalid), 80'(0));
        check("midreset_cnt", {32'h0, o_good_frames, o_err_drops, o_ovf_drops}, '0);
        ready_mode = 1;
        send_frame(5, F_GOOD, 8'h7F, 1'b0, tl);
        wait_drain("drain_postreset", 100);
        check("count_postreset", 80'(popped), 80'(5));
        check_counters("cnt_postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
